// File: rtl/cla_seq_add_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cla_seq_add_ctrl_pkg
// Shared definitions for the chunk-serial carry-lookahead adder sequencer:
//   CHUNK_W      width of the shared lookahead slice (4 bits)
//   state_e      controller state encoding (2-bit, one code spare)
//   nchunk_f     number of slice passes for a given operand width
//   signed_ovf_f two's-complement overflow from the operand/result sign bits
// ----------------------------------------------------------------------------
package cla_seq_add_ctrl_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_e;

    // Number of slice passes needed to cover an operand of the given width.
    function automatic int nchunk_f(input int width);
        return width / CHUNK_W;
    endfunction

    // Overflow occurs when both addends share a sign and the result does not.
    function automatic logic signed_ovf_f(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : cla_seq_add_ctrl_pkg

// File: rtl/cla_seq_add_ctrl_cla4_slice.sv
// ----------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a[3:0], b[3:0]  addends
//   ci              carry-in
//   s[3:0]          sum
//   co              carry-out, computed directly from generate/propagate terms
// ----------------------------------------------------------------------------
module cla4_slice
    import cla_seq_add_ctrl_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               ci,
    output logic [CHUNK_W-1:0] s,
    output logic               co
);

    logic [CHUNK_W-1:0] p_s;
    logic [CHUNK_W-1:0] g_s;
    logic [CHUNK_W-1:0] c_s;

    // Lookahead carries: every carry is a flat sum of products of g/p and ci.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = ci;
        c_s[1] = g_s[0] | (p_s[0] & ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci);
        co     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
        s      = p_s ^ c_s;
    end

endmodule : cla4_slice

// File: rtl/cla_seq_add_ctrl.sv
// ----------------------------------------------------------------------------
// cla_seq_add_ctrl
// Adds two WIDTH-bit operands by time-multiplexing one 4-bit lookahead slice,
// one chunk per clock, LSB chunk first. The inter-chunk carry is registered.
// Build option: define CLA_SEQ_SUB_EN to add the sub input and ovf output
// (a - b via ~b and forced carry-in of 1).
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, only honoured while idle
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   sub    (CLA_SEQ_SUB_EN) subtract request, captured with the operands
//   busy   add in progress
//   done   one-cycle completion pulse
//   sum    registered result, held until the next completion
//   cout   registered carry-out of the MSB chunk (1 = no borrow when sub)
//   ovf    (CLA_SEQ_SUB_EN) signed overflow of the final result
// ----------------------------------------------------------------------------
module cla_seq_add_ctrl
    import cla_seq_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNK = nchunk_f(WIDTH);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WIDTH-1:0]     a_lat_q;
    logic [WIDTH-1:0]     b_lat_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cout_q;
`ifdef CLA_SEQ_SUB_EN
    logic                 ovf_q;
`endif

    logic [WIDTH-1:0]     b_in_s;
    logic                 c_in_s;
    logic [CHUNK_W-1:0]   slice_a_s;
    logic [CHUNK_W-1:0]   slice_b_s;
    logic [CHUNK_W-1:0]   slice_sum_s;
    logic                 slice_co_s;
    logic                 last_s;

    // Operand conditioning at capture time: subtraction stores ~b and forces carry-in.
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            b_in_s = ~b;
            c_in_s = 1'b1;
        end else begin
            b_in_s = b;
            c_in_s = cin;
        end
`else
        b_in_s = b;
        c_in_s = cin;
`endif
    end

    // Select the current chunk and merge the slice result into the accumulator.
    always_comb begin
        slice_a_s = a_lat_q[idx_q*CHUNK_W +: CHUNK_W];
        slice_b_s = b_lat_q[idx_q*CHUNK_W +: CHUNK_W];
        last_s    = (idx_q == IDX_W'(NCHUNK - 1));
        acc_d     = acc_q;
        acc_d[idx_q*CHUNK_W +: CHUNK_W] = slice_sum_s;
    end

    cla4_slice u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_q),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Controller FSM with registered outputs; sum/cout only move on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_lat_q <= {WIDTH{1'b0}};
            b_lat_q <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_lat_q <= a;
                        b_lat_q <= b_in_s;
                        carry_q <= c_in_s;
                        idx_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_co_s;
                    if (last_s) begin
                        sum_q   <= acc_d;
                        cout_q  <= slice_co_s;
`ifdef CLA_SEQ_SUB_EN
                        ovf_q   <= signed_ovf_f(a_lat_q[WIDTH-1], b_lat_q[WIDTH-1],
                                                acc_d[WIDTH-1]);
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= {IDX_W{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    // Spare encoding: recover to idle without producing a result.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CLA_SEQ_SUB_EN
    assign ovf  = ovf_q;
`endif

endmodule : cla_seq_add_ctrl

// File: doc/cla_seq_add_ctrl.md
Name: cla_seq_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-multiplexing one 4-bit carry-lookahead slice, one 4-bit chunk per clock, LSB chunk first.
- Carry between chunks is held in a register.
- Sits between a requester (start/done handshake) and the shared 4-bit lookahead adder slice, giving wide adds at 4-bit-slice area cost.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NCHUNK, WIDTH/4 (derived localparam, not overridable), number of slice passes per add.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of the MSB chunk.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0; chunk index, operand latches and carry register cleared. rst overrides every other input.
- States:
  - IDLE: start=1 latches a, b, cin; idx=0; carry_reg=cin; ->RUN; busy=1 from the next cycle. start=0 stays IDLE.
  - RUN: each edge feeds slice operands a_lat[4*idx+:4], b_lat[4*idx+:4] and carry_reg; writes slice sum into acc[4*idx+:4]; carry_reg <= slice carry-out; idx <= idx+1.
  - Last chunk (idx==NCHUNK-1): sum <= full accumulator including this chunk; cout <= slice carry-out; done=1 for exactly one cycle; busy=0; ->IDLE.
- Latency: start accepted at edge E; done and result visible after edge E+NCHUNK. Example: WIDTH=16 gives 4 cycles.
- start while busy: ignored, not queued. Operand changes during RUN have no effect.
- Back-to-back: start high in the done cycle (state is IDLE) is accepted; no dead cycle.
- done is never asserted on the same cycle as busy.
- sum/cout never show partial results; they change only on the completion edge or reset.
- Reset mid-operation: add abandoned, no done pulse, outputs return to reset values.
- idx wraps only via return to IDLE; it never exceeds NCHUNK-1.
- Arithmetic is modulo 2^WIDTH; the carry-out goes only to cout.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, the latch stores ~b and carry_reg is loaded with 1 (cin ignored), so the result is a-b mod 2^WIDTH.
  - cout=1 means no borrow.
  - Adds output ovf (1 bit, reset 0): signed overflow of the final result, updated with sum.
- Undefined: no sub or ovf ports; add only.

Decomposition:
- Shared package/header:
  - CHUNK_W=4.
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1 (2-bit, one code spare).
  - Rule NCHUNK=WIDTH/CHUNK_W.
- One sub-module, cla4_slice: purely combinational 4-bit lookahead adder, ports a[3:0], b[3:0], ci, s[3:0], co. Instantiated once.
- The controller holds all state: FSM, idx, operand latches, accumulator, carry register, output registers.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, start 1 cycle -> busy high 4 cycles; done pulse after 4th edge; sum=0x0000, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; no intermediate value ever appears on sum.
- Start 0x00FF+0x0001; assert start again with 0xAAAA+0x5555 at cycle 2 -> second request ignored; sum=0x0100, cout=0, single done.
- Start 0x8000+0x8000; assert rst at cycle 2 -> next cycle busy=0, sum=0, cout=0; no done pulse; new add 0x0003+0x0004 afterwards gives 0x0007.
- Back-to-back: start held in the done cycle of 0x0001+0x0001 with new operands 0x7FFF+0x0001 -> first sum=0x0002; second done 4 cycles later, sum=0x8000, cout=0.
- CLA_SEQ_SUB_EN defined, sub=1:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
